// File: rtl/gravity_step.sv
// gravity_step: iterates a simple vertical-motion model for n_i steps.
// Each step first subtracts gravity from the velocity, then adds the new
// velocity to the position. All arithmetic saturates to the signed W-bit range.
//
// state | meaning
// IDLE  | waiting for start_i, results held
// SUB_V | vy <= sat(vy - g)
// ADD_Y | y <= sat(y + vy), count one step
// DONE  | one-cycle completion pulse
module gravity_step #(
  parameter int W  = 17,
  parameter int NW = 4
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          start_i,
  input  logic [NW-1:0] n_i,
  input  logic [W-1:0]  vy_i,
  input  logic [W-1:0]  y_i,
  input  logic [W-1:0]  g_i,
  output logic [W-1:0]  vy_o,
  output logic [W-1:0]  y_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          sat_o
);

  typedef enum logic [1:0] {IDLE, SUB_V, ADD_Y, DONE} state_t;

  localparam logic [W-1:0] MAX_POS = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

  state_t        state_q, state_d;
  logic [W-1:0]  vy_q, vy_d;
  logic [W-1:0]  y_q, y_d;
  logic [W-1:0]  g_q, g_d;
  logic [NW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          sat_q, sat_d;

  logic [W:0]    vy_diff;
  logic [W:0]    y_sum;

  // One guard bit is enough: the top two bits disagree only on overflow.
  assign vy_diff = {vy_q[W-1], vy_q} - {g_q[W-1], g_q};
  assign y_sum   = {y_q[W-1], y_q} + {vy_q[W-1], vy_q};

  function automatic logic [W-1:0] sat_val(input logic [W:0] v);
    case (v[W:W-1])
      2'b01:   sat_val = MAX_POS;
      2'b10:   sat_val = MIN_NEG;
      default: sat_val = v[W-1:0];
    endcase
  endfunction

  function automatic logic ovf(input logic [W:0] v);
    ovf = v[W] ^ v[W-1];
  endfunction

  // Next-state and datapath computation.
  always_comb begin
    state_d = state_q;
    vy_d    = vy_q;
    y_d     = y_q;
    g_d     = g_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    sat_d   = sat_q;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start_i) begin
          vy_d   = vy_i;
          y_d    = y_i;
          g_d    = g_i;
          cnt_d  = n_i;
          sat_d  = 1'b0;
          busy_d = 1'b1;
          if (n_i == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = SUB_V;
          end
        end
      end
      SUB_V: begin
        vy_d    = sat_val(vy_diff);
        sat_d   = sat_q | ovf(vy_diff);
        state_d = ADD_Y;
      end
      ADD_Y: begin
        y_d   = sat_val(y_sum);
        sat_d = sat_q | ovf(y_sum);
        cnt_d = cnt_q - NW'(1);
        if (cnt_q == NW'(1)) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          state_d = SUB_V;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and result registers; reset aborts any run immediately.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      vy_q    <= '0;
      y_q     <= '0;
      g_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      vy_q    <= vy_d;
      y_q     <= y_d;
      g_q     <= g_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sat_q   <= sat_d;
    end
  end

  assign vy_o   = vy_q;
  assign y_o    = y_q;
  assign busy_o = busy_q;
  assign done_o = done_q;
  assign sat_o  = sat_q;

endmodule

// File: tb/tb_gravity_step.sv
// Bench for gravity_step: vector table driven back-to-back through a
// scoreboard queue, plus busy-window and reset-abort sequences.
module tb_gravity_step;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [3:0]  n;
  logic [16:0] vy, y, g;
  logic [16:0] vy_o, y_o;
  logic        busy_o, done_o, sat_o;

  gravity_step #(.W(17), .NW(4)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .start_i (start),
    .n_i     (n),
    .vy_i    (vy),
    .y_i     (y),
    .g_i     (g),
    .vy_o    (vy_o),
    .y_o     (y_o),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .sat_o   (sat_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int n; int vy; int y; int g;
    int e_vy; int e_y; int e_sat;
  } vec_t;

  typedef struct {
    int n; int e_vy; int e_y; int e_sat; int cyc0;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding run.
  always @(negedge clk) begin
    if (rst_n && done_o) begin
      if (q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("vy_o", int'($signed(vy_o)), e.e_vy);
        check("y_o", int'($signed(y_o)), e.e_y);
        check("sat_o", int'(sat_o), e.e_sat);
        check("latency", cyc - e.cyc0, 2 * e.n + 1);
      end
    end
  end

  task automatic drive(input vec_t v);
    exp_t e;
    n     = v.n[3:0];
    vy    = v.vy[16:0];
    y     = v.y[16:0];
    g     = v.g[16:0];
    start = 1'b1;
    e.n = v.n; e.e_vy = v.e_vy; e.e_y = v.e_y; e.e_sat = v.e_sat; e.cyc0 = cyc;
    q.push_back(e);
  endtask

  // Called at a negedge; starts as soon as the DUT is idle, then scrambles
  // operands and pulses start while busy to show both are ignored.
  task automatic run(input vec_t v);
    int budget = 0;
    while (busy_o && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 100) check("idle_timeout", 0, 1);
    drive(v);
    @(negedge clk);
    vy    = 17'($urandom);
    y     = 17'($urandom);
    g     = 17'($urandom);
    n     = 4'($urandom);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    int budget = 0;
    while (q.size() > 0 && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    check("queue_drain", q.size(), 0);
  endtask

  vec_t vecs[10];
  vec_t v;

  initial begin
    vecs[0] = '{1, 0, 1000, 10, -10, 990, 0};
    vecs[1] = '{3, 100, 0, 10, 70, 240, 0};
    vecs[2] = '{1, -65530, 0, 10, -65536, -65536, 1};
    vecs[3] = '{2, 1, 2, -3, 7, 13, 0};
    vecs[4] = '{0, 5, 7, 99, 5, 7, 0};
    vecs[5] = '{1, 65535, 0, -1, 65535, 65535, 1};
    vecs[6] = '{1, 60000, 60000, 0, 60000, 65535, 1};
    vecs[7] = '{15, 0, 0, 1, -15, -120, 0};
    vecs[8] = '{2, -65530, 0, 10, -65536, -65536, 1};
    vecs[9] = '{1, 0, 1000, 10, -10, 990, 0};

    rst_n = 1'b0; start = 1'b0; n = '0; vy = '0; y = '0; g = '0;
    repeat (3) @(negedge clk);
    check("rst_vy", int'(vy_o), 0);
    check("rst_y", int'(y_o), 0);
    check("rst_busy", int'(busy_o), 0);
    check("rst_done", int'(done_o), 0);
    check("rst_sat", int'(sat_o), 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) run(vecs[i]);
    drain();

    // Busy window for a 3-step run: cycles 1..7 high, cycle 8 low.
    v = '{3, 100, 0, 10, 70, 240, 0};
    drive(v);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      start = 1'b0;
      check($sformatf("busy_c%0d", k), int'(busy_o), (k <= 7) ? 1 : 0);
    end
    drain();
    check("sat_hold_after_clear", int'(sat_o), 0);

    // Reset mid-run: 8-step run aborted in cycle 5.
    n = 4'd8; vy = '0; y = '0; g = 17'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("midrun_busy", int'(busy_o), 1);
    check("midrun_vy_nonzero", int'(vy_o != '0), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_vy", int'(vy_o), 0);
    check("async_y", int'(y_o), 0);
    check("async_busy", int'(busy_o), 0);
    check("async_done", int'(done_o), 0);
    check("async_sat", int'(sat_o), 0);
    repeat (2) @(negedge clk);
    check("rst_hold_done", int'(done_o), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_busy", int'(busy_o), 0);
    v = '{2, 0, 0, 1, -2, -3, 0};
    run(v);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
